// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// lcd_hd44780_responder : panel-side HD44780 8-bit bus responder with 80-byte
// DDRAM, address counter, mode flags, busy/error status and DDRAM read port.
// Revision 1.0
// ============================================================================
module lcd_hd44780_responder #(
   parameter int MIN_EN_CYCLES     = 8,
   parameter int BUSY_CYCLES       = 2160,
   parameter int CLEAR_BUSY_CYCLES = 82080
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_en,
   input  logic [7:0] lcd_data,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [6:0] cursor_addr,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       incr_mode,
   output logic       busy,
   output logic       cmd_strobe,
   output logic       char_strobe,
   output logic       proto_err
);

   localparam int c_cnt_max = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
   localparam int c_cw      = $clog2(c_cnt_max + 1);
   localparam int c_ew      = $clog2(MIN_EN_CYCLES + 1);
   localparam logic [c_cw-1:0] c_busy_ld = c_cw'(BUSY_CYCLES - 1);
   localparam logic [c_cw-1:0] c_clr_ld  = c_cw'(CLEAR_BUSY_CYCLES - 1);
   localparam logic [c_ew-1:0] c_en_min  = c_ew'(MIN_EN_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EXEC     = 2'd1,
      S_CLEAR    = 2'd2,
      S_CLR_WAIT = 2'd3
   } state_t;

   // Returns {valid, ddram_index} for an AC value under the given line mode.
   function automatic logic [7:0] f_index(input logic [6:0] a, input logic tl);
      logic [7:0] r;
      r = 8'h00;
      if (!tl) begin
         if (a < 7'h50) r = {1'b1, a};
      end else if (a <= 7'h27) begin
         r = {1'b1, a};
      end else if (a >= 7'h40 && a <= 7'h67) begin
         r = {1'b1, a - 7'h18};
      end
      return r;
   endfunction

   function automatic logic [6:0] f_step(input logic [6:0] a, input logic tl, input logic up);
      logic [6:0] n;
      if (up) begin
         if (!tl)             n = (a == 7'h4F) ? 7'h00 : a + 7'h01;
         else if (a == 7'h27) n = 7'h40;
         else if (a == 7'h67) n = 7'h00;
         else                 n = a + 7'h01;
      end else begin
         if (!tl)             n = (a == 7'h00) ? 7'h4F : a - 7'h01;
         else if (a == 7'h40) n = 7'h27;
         else if (a == 7'h00) n = 7'h67;
         else                 n = a - 7'h01;
      end
      return n;
   endfunction

   // Bus vector layout: {rs, rw, en, data[7:0]}
   logic [10:0]     sync1_q, sync2_q, prev_q;
   logic [c_ew-1:0] en_cnt_q, en_cnt_d;
   logic            req_q, req_d;
   logic [9:0]      req_bus_q, req_bus_d;
   state_t          state_q, state_d;
   logic [c_cw-1:0] cnt_q, cnt_d;
   logic [6:0]      fill_q, fill_d;
   logic [6:0]      ac_q, ac_d;
   logic            disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic            tl_q, tl_d, inc_q, inc_d, cg_q, cg_d;
   logic            cmd_q, cmd_d, char_q, char_d, err_q, err_set;
   logic [7:0]      rd_data_q;
   logic [7:0]      mem_q [80];

   logic            w_we;
   logic [6:0]      w_widx;
   logic [7:0]      w_wdata;
   logic            w_fall;
   logic [7:0]      w_ac_idx, w_set_idx, w_rd_idx;
   logic [7:0]      w_d;

   assign w_fall   = prev_q[8] & ~sync2_q[8];
   assign w_ac_idx = f_index(ac_q, tl_q);
   assign w_rd_idx = f_index(rd_addr, tl_q);
   assign w_d      = req_bus_q[7:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fill_d    = fill_q;
      ac_d      = ac_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      blink_d   = blink_q;
      tl_d      = tl_q;
      inc_d     = inc_q;
      cg_d      = cg_q;
      cmd_d     = 1'b0;
      char_d    = 1'b0;
      err_set   = 1'b0;
      w_we      = 1'b0;
      w_widx    = fill_q;
      w_wdata   = 8'h20;
      w_set_idx = 8'h00;
      req_d     = 1'b0;
      req_bus_d = req_bus_q;
      en_cnt_d  = '0;

      if (sync2_q[8]) en_cnt_d = (en_cnt_q >= c_en_min) ? en_cnt_q : en_cnt_q + 1'b1;

      if (w_fall) begin
         if (en_cnt_q >= c_en_min) begin
            req_d     = 1'b1;
            req_bus_d = {prev_q[10], prev_q[9], prev_q[7:0]};
         end else begin
            err_set = 1'b1;
         end
      end

      case (state_q)
         S_CLEAR: begin
            w_we = 1'b1;
            if (fill_q == 7'd79) begin
               state_d = S_CLR_WAIT;
               cnt_d   = c_clr_ld;
               fill_d  = 7'd0;
            end else begin
               fill_d = fill_q + 7'd1;
            end
         end
         S_EXEC, S_CLR_WAIT: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase

      if (req_q) begin
         if (req_bus_q[8] || state_q != S_IDLE) begin
            err_set = 1'b1;
         end else if (req_bus_q[9]) begin
            char_d  = 1'b1;
            state_d = S_EXEC;
            cnt_d   = c_busy_ld;
            // While addressing CGRAM the byte is swallowed and AC is left alone.
            if (!cg_q) begin
               if (w_ac_idx[7]) begin
                  w_we    = 1'b1;
                  w_widx  = w_ac_idx[6:0];
                  w_wdata = w_d;
               end
               ac_d = f_step(ac_q, tl_q, inc_q);
            end
         end else begin
            cmd_d   = 1'b1;
            state_d = S_EXEC;
            cnt_d   = c_busy_ld;
            if (w_d[7]) begin
               cg_d      = 1'b0;
               w_set_idx = f_index(w_d[6:0], tl_q);
               if (w_set_idx[7]) begin
                  ac_d = w_d[6:0];
               end else begin
                  ac_d    = 7'd0;
                  err_set = 1'b1;
               end
            end else if (w_d[6]) begin
               cg_d = 1'b1;
            end else if (w_d[5]) begin
               tl_d = w_d[3];
            end else if (w_d[4]) begin
               if (!w_d[3]) ac_d = f_step(ac_q, tl_q, w_d[2]);
            end else if (w_d[3]) begin
               disp_d  = w_d[2];
               cur_d   = w_d[1];
               blink_d = w_d[0];
            end else if (w_d[2]) begin
               inc_d = w_d[1];
            end else if (w_d[1]) begin
               ac_d    = 7'd0;
               state_d = S_CLR_WAIT;
               cnt_d   = c_clr_ld;
            end else if (w_d[0]) begin
               ac_d    = 7'd0;
               inc_d   = 1'b1;
               cg_d    = 1'b0;
               state_d = S_CLEAR;
               fill_d  = 7'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         en_cnt_q  <= '0;
         req_q     <= 1'b0;
         req_bus_q <= '0;
         state_q   <= S_CLEAR;
         cnt_q     <= '0;
         fill_q    <= 7'd0;
         ac_q      <= 7'd0;
         disp_q    <= 1'b0;
         cur_q     <= 1'b0;
         blink_q   <= 1'b0;
         tl_q      <= 1'b0;
         inc_q     <= 1'b1;
         cg_q      <= 1'b0;
         cmd_q     <= 1'b0;
         char_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         sync1_q   <= {lcd_rs, lcd_rw, lcd_en, lcd_data};
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         en_cnt_q  <= en_cnt_d;
         req_q     <= req_d;
         req_bus_q <= req_bus_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fill_q    <= fill_d;
         ac_q      <= ac_d;
         disp_q    <= disp_d;
         cur_q     <= cur_d;
         blink_q   <= blink_d;
         tl_q      <= tl_d;
         inc_q     <= inc_d;
         cg_q      <= cg_d;
         cmd_q     <= cmd_d;
         char_q    <= char_d;
         err_q     <= err_q | err_set;
         rd_data_q <= w_rd_idx[7] ? mem_q[w_rd_idx[6:0]] : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) mem_q[w_widx] <= w_wdata;
   end

   assign rd_data     = rd_data_q;
   assign cursor_addr = ac_q;
   assign display_on  = disp_q;
   assign cursor_on   = cur_q;
   assign blink_on    = blink_q;
   assign two_line    = tl_q;
   assign incr_mode   = inc_q;
   assign busy        = (state_q != S_IDLE);
   assign cmd_strobe  = cmd_q;
   assign char_strobe = char_q;
   assign proto_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// tb_lcd_hd44780_responder : self-checking bench with a linear-position DDRAM
// reference model, directed vector table and randomized instruction stream.
// Revision 1.0
// ============================================================================
module tb_lcd_hd44780_responder;

   localparam int MIN_EN    = 8;
   localparam int BUSY_C    = 40;
   localparam int CLR_C     = 200;
   localparam int FILL_BUSY = 80 + CLR_C;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [6:0] rd_addr = 7'h00;
   logic [7:0] rd_data;
   logic [6:0] cursor_addr;
   logic       display_on, cursor_on, blink_on, two_line, incr_mode;
   logic       busy, cmd_strobe, char_strobe, proto_err;

   always #5 clk = ~clk;

   lcd_hd44780_responder #(
      .MIN_EN_CYCLES    (MIN_EN),
      .BUSY_CYCLES      (BUSY_C),
      .CLEAR_BUSY_CYCLES(CLR_C)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_data   (lcd_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .cursor_addr(cursor_addr),
      .display_on (display_on),
      .cursor_on  (cursor_on),
      .blink_on   (blink_on),
      .two_line   (two_line),
      .incr_mode  (incr_mode),
      .busy       (busy),
      .cmd_strobe (cmd_strobe),
      .char_strobe(char_strobe),
      .proto_err  (proto_err)
   );

   int nchk = 0;
   int nerr = 0;
   int dut_ncmd, dut_nchar;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dut_ncmd  <= 0;
         dut_nchar <= 0;
      end else begin
         if (cmd_strobe)  dut_ncmd  <= dut_ncmd + 1;
         if (char_strobe) dut_nchar <= dut_nchar + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model: DDRAM as 80 linear positions ----------
   logic [7:0] m_mem [80];
   logic [6:0] m_ac;
   bit         m_tl, m_inc, m_d, m_c, m_b, m_cg, m_err;
   int         m_ncmd, m_nchar;

   function automatic int m_lin(input logic [6:0] a, input bit tl);
      int v;
      v = int'(a);
      if (!tl) return (v < 80) ? v : -1;
      if (v < 40) return v;
      if (v >= 64 && v < 104) return v - 24;
      return -1;
   endfunction

   function automatic logic [6:0] m_addr(input int p, input bit tl);
      return 7'((tl && p >= 40) ? p + 24 : p);
   endfunction

   function automatic logic [6:0] m_move(input logic [6:0] a, input bit tl, input bit up);
      int p;
      p = m_lin(a, tl);
      p = (p + (up ? 1 : 79)) % 80;
      return m_addr(p, tl);
   endfunction

   function automatic logic [7:0] m_rd(input logic [6:0] a);
      int p;
      p = m_lin(a, m_tl);
      return (p < 0) ? 8'h00 : m_mem[p];
   endfunction

   task automatic m_init();
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      m_ac = 7'h00; m_tl = 0; m_inc = 1; m_d = 0; m_c = 0; m_b = 0;
      m_cg = 0; m_err = 0; m_ncmd = 0; m_nchar = 0;
   endtask

   task automatic m_apply(input bit rs, input logic [7:0] d);
      int p;
      if (rs) begin
         m_nchar++;
         if (!m_cg) begin
            p = m_lin(m_ac, m_tl);
            if (p >= 0) m_mem[p] = d;
            m_ac = m_move(m_ac, m_tl, m_inc);
         end
      end else begin
         m_ncmd++;
         casez (d)
            8'b1???????: begin
               m_cg = 0;
               if (m_lin(d[6:0], m_tl) >= 0) m_ac = d[6:0];
               else begin m_ac = 7'h00; m_err = 1; end
            end
            8'b01??????: m_cg = 1;
            8'b001?????: m_tl = d[3];
            8'b0001????: if (!d[3]) m_ac = m_move(m_ac, m_tl, d[2]);
            8'b00001???: begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
            8'b000001??: m_inc = d[1];
            8'b0000001?: m_ac = 7'h00;
            8'b00000001: begin
               m_ac = 7'h00; m_inc = 1; m_cg = 0;
               for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
            end
            default: ;
         endcase
      end
   endtask

   // ---------------- bus driving ---------------------------------------------
   task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int hi);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
      repeat (hi) @(negedge clk);
      lcd_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         nchk++; nerr++;
         $display("FAIL %s: busy still high after %0d cycles", name, n);
      end
   endtask

   task automatic send(input bit rs, input logic [7:0] d);
      strobe(rs, 1'b0, d, MIN_EN + $urandom_range(0, 3));
      m_apply(rs, d);
      repeat (6) @(negedge clk);
      wait_idle("send_idle");
   endtask

   task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      chk(name, rd_data, exp);
   endtask

   task automatic cmp_state(input string tag);
      chk({tag, "_cursor"}, cursor_addr, m_ac);
      chk({tag, "_dcb"}, {display_on, cursor_on, blink_on}, {m_d, m_c, m_b});
      chk({tag, "_two_line"}, two_line, m_tl);
      chk({tag, "_incr"}, incr_mode, m_inc);
      chk({tag, "_proto_err"}, proto_err, m_err);
   endtask

   task automatic fill_chk(input string name);
      int bad;
      bad = 0;
      for (int a = 0; a < 80; a++) begin
         @(negedge clk);
         rd_addr = 7'(a);
         @(negedge clk);
         if (rd_data !== 8'h20) bad++;
      end
      chk(name, bad, 0);
   endtask

   task automatic do_reset(input string tag);
      int n;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_busy_in_reset"}, busy, 1'b1);
      chk({tag, "_rd_in_reset"}, rd_data, 8'h00);
      reset = 1'b1;
      m_init();
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, n, FILL_BUSY);
      cmp_state(tag);
   endtask

   // ---------------- directed vector table ----------------------------------
   typedef struct {
      bit         rs;
      logic [7:0] d;
      logic [6:0] exp_ac;
   } vec_t;

   vec_t tv [11];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{1'b0, 8'h38, 7'h00};
      tv[1]  = '{1'b0, 8'h01, 7'h00};
      tv[2]  = '{1'b0, 8'h0C, 7'h00};
      tv[3]  = '{1'b0, 8'h06, 7'h00};
      tv[4]  = '{1'b0, 8'h80, 7'h00};
      tv[5]  = '{1'b1, "K",   7'h01};
      tv[6]  = '{1'b1, "i",   7'h02};
      tv[7]  = '{1'b1, "m",   7'h03};
      tv[8]  = '{1'b0, 8'hC0, 7'h40};
      tv[9]  = '{1'b1, "@",   7'h41};
      tv[10] = '{1'b1, "?",   7'h42};

      m_init();
      do_reset("rst0");
      chk("rst0_strobes", {cmd_strobe, char_strobe}, 2'b00);
      fill_chk("rst0_fill");

      for (int i = 0; i < 11; i++) begin
         send(tv[i].rs, tv[i].d);
         chk($sformatf("vec%0d_cursor", i), cursor_addr, tv[i].exp_ac);
      end
      chk("vec_two_line", two_line, 1'b1);
      chk("vec_display", {display_on, cursor_on}, 2'b10);
      rd_chk("vec_rd00", 7'h00, "K");
      rd_chk("vec_rd01", 7'h01, "i");
      rd_chk("vec_rd02", 7'h02, "m");
      rd_chk("vec_rd40", 7'h40, 8'h40);
      rd_chk("vec_rd41", 7'h41, 8'h3F);
      chk("vec_cmd_count", dut_ncmd, m_ncmd);
      chk("vec_char_count", dut_nchar, 5);

      // Two-line wrap points
      send(1'b0, 8'hA7);
      send(1'b1, "A");
      rd_chk("wrap_rd27", 7'h27, "A");
      chk("wrap_27_to_40", cursor_addr, 7'h40);
      send(1'b0, 8'hE7);
      send(1'b1, "B");
      rd_chk("wrap_rd67", 7'h67, "B");
      chk("wrap_67_to_00", cursor_addr, 7'h00);

      // One-line decrement wrap
      send(1'b0, 8'h04);
      send(1'b0, 8'h30);
      send(1'b0, 8'h80);
      send(1'b1, "x");
      chk("dec_wrap_4f", cursor_addr, 7'h4F);
      rd_chk("dec_rd00", 7'h00, "x");
      cmp_state("dir");

      // Randomized instruction stream against the model
      for (int it = 0; it < 60; it++) begin
         int         cat, p;
         bit         rs, nb;
         logic [7:0] d;
         logic [6:0] ra;
         rs  = 1'b0;
         d   = 8'($urandom);
         cat = $urandom_range(0, 11);
         case (cat)
            0, 1, 2, 3: begin rs = 1'b1; d = 8'($urandom_range(32, 126)); end
            4: begin p = $urandom_range(0, 79); d = {1'b1, m_addr(p, m_tl)}; end
            5: begin
               nb = 1'($urandom_range(0, 1));
               if (m_lin(m_ac, nb) < 0) d = {5'b00001, d[2:0]};
               else                     d = {3'b001, d[4], nb, d[2:0]};
            end
            6:  d = {4'b0001, d[3:0]};
            7:  d = {5'b00001, d[2:0]};
            8:  d = {6'b000001, d[1:0]};
            9:  d = {2'b01, d[5:0]};
            10: d = {7'b0000001, d[0]};
            default: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
         endcase
         send(rs, d);
         cmp_state($sformatf("rand%0d", it));
         ra = 7'($urandom_range(0, 127));
         rd_chk($sformatf("rand%0d_rd", it), ra, m_rd(ra));
      end
      chk("rand_cmd_count", dut_ncmd, m_ncmd);
      chk("rand_char_count", dut_nchar, m_nchar);

      // Short enable pulse is rejected
      do_reset("rst1");
      strobe(1'b1, 1'b0, 8'h5A, MIN_EN - 2);
      repeat (10) @(negedge clk);
      m_err = 1;
      chk("short_not_busy", busy, 1'b0);
      cmp_state("short");
      rd_chk("short_rd00", 7'h00, 8'h20);

      // Read strobe is rejected
      do_reset("rst2");
      strobe(1'b1, 1'b1, 8'h52, MIN_EN + 2);
      repeat (10) @(negedge clk);
      m_err = 1;
      chk("rw_not_busy", busy, 1'b0);
      cmp_state("rw");

      // Strobe while busy is rejected, error stays sticky
      do_reset("rst3");
      strobe(1'b1, 1'b0, "Z", MIN_EN + 2);
      m_apply(1'b1, "Z");
      repeat (6) @(negedge clk);
      strobe(1'b1, 1'b0, "Q", MIN_EN + 2);
      m_err = 1;
      repeat (6) @(negedge clk);
      wait_idle("busy_idle");
      cmp_state("busyrej");
      rd_chk("busyrej_rd00", 7'h00, "Z");
      rd_chk("busyrej_rd01", 7'h01, 8'h20);
      send(1'b1, "V");
      cmp_state("sticky");
      rd_chk("sticky_rd01", 7'h01, "V");

      // Address outside the two-line window
      do_reset("rst4");
      send(1'b0, 8'h38);
      send(1'b0, 8'h85);
      chk("addr_pre", cursor_addr, 7'h05);
      send(1'b0, 8'hA8);
      chk("addr_bad_ac", cursor_addr, 7'h00);
      chk("addr_bad_err", proto_err, 1'b1);
      cmp_state("addr_bad");

      // Reset during the clear fill restarts it from the beginning
      send(1'b1, "W");
      strobe(1'b0, 1'b0, 8'h01, MIN_EN + 1);
      repeat (30) @(negedge clk);
      chk("midclear_busy", busy, 1'b1);
      do_reset("rst5");
      fill_chk("rst5_fill");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
